// File: rtl/hpdcache_cfg_ctrl.sv
// Runtime configuration block for the HPDcache: software writes go to shadow registers,
// which are copied to the active registers on APPLY once the cache has drained and stayed idle.
module hpdcache_cfg_ctrl #(
  parameter int unsigned WBUF_TIMECNT_WIDTH = 4,
  parameter int unsigned RTAB_ENTRIES       = 8,
  parameter int unsigned MSHR_WAYS          = 2,
  parameter int unsigned QUIESCE_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES     = 64,
  parameter int unsigned DATA_WIDTH         = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  cfg_req_valid_i,
  output logic                                  cfg_req_ready_o,
  input  logic                                  cfg_req_we_i,
  input  logic [1:0]                            cfg_req_addr_i,
  input  logic [DATA_WIDTH-1:0]                 cfg_req_wdata_i,
  output logic                                  cfg_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]                 cfg_rsp_rdata_o,
  output logic                                  cfg_rsp_error_o,
  input  logic                                  cache_idle_i,
  output logic                                  cache_hold_o,
  output logic [WBUF_TIMECNT_WIDTH-1:0]         cfg_wbuf_threshold_o,
  output logic                                  cfg_wbuf_rst_on_write_o,
  output logic [$clog2(RTAB_ENTRIES+1)-1:0]     cfg_rtab_limit_o,
  output logic [MSHR_WAYS-1:0]                  cfg_mshr_ways_mask_o,
  output logic                                  cfg_updated_o
);

  localparam int unsigned LIMIT_W = $clog2(RTAB_ENTRIES+1);
  localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYCLES+1);

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_WBUF  = 2'd1;
  localparam logic [1:0] ADDR_RTAB  = 2'd2;
  localparam logic [1:0] ADDR_MSHR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_APPLY
  } state_t;

  state_t                        state_q;
  logic [CNT_W-1:0]              idle_cnt_q;
  logic [CNT_W-1:0]              tmo_cnt_q;
  logic                          timeout_q;

  logic                          sh_rst_on_write_q;
  logic [WBUF_TIMECNT_WIDTH-1:0] sh_threshold_q;
  logic [LIMIT_W-1:0]            sh_rtab_limit_q;
  logic [MSHR_WAYS-1:0]          sh_mshr_mask_q;

  logic                          accept;
  logic                          wr_err;
  logic                          apply_req;
  logic [DATA_WIDTH-1:0]         rd_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign cfg_req_ready_o = (state_q == ST_IDLE);
  assign cache_hold_o    = (state_q != ST_IDLE);
  assign accept          = cfg_req_valid_i & cfg_req_ready_o;
  assign apply_req       = accept & cfg_req_we_i & (cfg_req_addr_i == ADDR_CTRL) & cfg_req_wdata_i[1];

  always_comb begin
    wr_err = 1'b0;
    if (cfg_req_we_i) begin
      case (cfg_req_addr_i)
        ADDR_RTAB: wr_err = (cfg_req_wdata_i == '0) ||
                            (cfg_req_wdata_i > DATA_WIDTH'(RTAB_ENTRIES));
        ADDR_MSHR: wr_err = (cfg_req_wdata_i[MSHR_WAYS-1:0] == '0);
        default:   wr_err = 1'b0;
      endcase
    end
  end

  // Reads always reflect the shadow copy, so software sees what the next APPLY will install.
  always_comb begin
    rd_data = '0;
    case (cfg_req_addr_i)
      ADDR_CTRL: begin
        rd_data[0] = sh_rst_on_write_q;
        rd_data[2] = (state_q != ST_IDLE);
        rd_data[3] = timeout_q;
      end
      ADDR_WBUF: rd_data[WBUF_TIMECNT_WIDTH-1:0] = sh_threshold_q;
      ADDR_RTAB: rd_data[LIMIT_W-1:0]            = sh_rtab_limit_q;
      ADDR_MSHR: rd_data[MSHR_WAYS-1:0]          = sh_mshr_mask_q;
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q                 <= ST_IDLE;
      idle_cnt_q              <= '0;
      tmo_cnt_q               <= '0;
      timeout_q               <= 1'b0;
      sh_rst_on_write_q       <= 1'b1;
      sh_threshold_q          <= WBUF_TIMECNT_WIDTH'(3);
      sh_rtab_limit_q         <= LIMIT_W'(RTAB_ENTRIES);
      sh_mshr_mask_q          <= '1;
      cfg_wbuf_rst_on_write_o <= 1'b1;
      cfg_wbuf_threshold_o    <= WBUF_TIMECNT_WIDTH'(3);
      cfg_rtab_limit_o        <= LIMIT_W'(RTAB_ENTRIES);
      cfg_mshr_ways_mask_o    <= '1;
      cfg_rsp_valid_o         <= 1'b0;
      cfg_rsp_rdata_o         <= '0;
      cfg_rsp_error_o         <= 1'b0;
      cfg_updated_o           <= 1'b0;
    end else begin
      cfg_rsp_valid_o <= accept;
      cfg_rsp_rdata_o <= '0;
      cfg_rsp_error_o <= 1'b0;
      cfg_updated_o   <= 1'b0;

      if (accept) begin
        if (cfg_req_we_i) begin
          cfg_rsp_error_o <= wr_err;
          if (!wr_err) begin
            case (cfg_req_addr_i)
              ADDR_CTRL: begin
                sh_rst_on_write_q <= cfg_req_wdata_i[0];
                if (cfg_req_wdata_i[3]) timeout_q <= 1'b0;
              end
              ADDR_WBUF: sh_threshold_q  <= cfg_req_wdata_i[WBUF_TIMECNT_WIDTH-1:0];
              ADDR_RTAB: sh_rtab_limit_q <= cfg_req_wdata_i[LIMIT_W-1:0];
              ADDR_MSHR: sh_mshr_mask_q  <= cfg_req_wdata_i[MSHR_WAYS-1:0];
              default: ;
            endcase
          end
        end else begin
          cfg_rsp_rdata_o <= rd_data;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (apply_req) begin
            state_q    <= ST_DRAIN;
            idle_cnt_q <= '0;
            tmo_cnt_q  <= '0;
          end
        end
        ST_DRAIN: begin
          idle_cnt_q <= cache_idle_i ? sat_inc(idle_cnt_q) : '0;
          tmo_cnt_q  <= sat_inc(tmo_cnt_q);
          // Quiescence is checked first so a drain completing on the last allowed cycle still applies.
          if (cache_idle_i && (idle_cnt_q == CNT_W'(QUIESCE_CYCLES - 1))) begin
            state_q <= ST_APPLY;
          end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= ST_IDLE;
            timeout_q <= 1'b1;
          end
        end
        ST_APPLY: begin
          cfg_wbuf_rst_on_write_o <= sh_rst_on_write_q;
          cfg_wbuf_threshold_o    <= sh_threshold_q;
          cfg_rtab_limit_o        <= sh_rtab_limit_q;
          cfg_mshr_ways_mask_o    <= sh_mshr_mask_q;
          cfg_updated_o           <= 1'b1;
          state_q                 <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hpdcache_cfg_ctrl.sv
// Bench for hpdcache_cfg_ctrl: config responses go through a scoreboard queue,
// drain/apply timing and active outputs are checked cycle by cycle in each scenario task.
module tb_hpdcache_cfg_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        cache_idle;
  logic        cache_hold;
  logic [3:0]  thr;
  logic        rst_on_write;
  logic [3:0]  rtab_limit;
  logic [1:0]  mshr_mask;
  logic        updated;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  hpdcache_cfg_ctrl #(
    .WBUF_TIMECNT_WIDTH (4),
    .RTAB_ENTRIES       (8),
    .MSHR_WAYS          (2),
    .QUIESCE_CYCLES     (4),
    .TIMEOUT_CYCLES     (64),
    .DATA_WIDTH         (32)
  ) dut (
    .clk_i                   (clk),
    .rst_ni                  (rst_n),
    .cfg_req_valid_i         (req_valid),
    .cfg_req_ready_o         (req_ready),
    .cfg_req_we_i            (req_we),
    .cfg_req_addr_i          (req_addr),
    .cfg_req_wdata_i         (req_wdata),
    .cfg_rsp_valid_o         (rsp_valid),
    .cfg_rsp_rdata_o         (rsp_rdata),
    .cfg_rsp_error_o         (rsp_error),
    .cache_idle_i            (cache_idle),
    .cache_hold_o            (cache_hold),
    .cfg_wbuf_threshold_o    (thr),
    .cfg_wbuf_rst_on_write_o (rst_on_write),
    .cfg_rtab_limit_o        (rtab_limit),
    .cfg_mshr_ways_mask_o    (mshr_mask),
    .cfg_updated_o           (updated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Response monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got rdata=0x%0h err=%0b with no request outstanding", rsp_rdata, rsp_error);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (rsp_rdata !== e.rdata || rsp_error !== e.err) begin
          failures++;
          $display("FAIL rsp: got rdata=0x%0h err=%0b, expected rdata=0x%0h err=%0b",
                   rsp_rdata, rsp_error, e.rdata, e.err);
        end
      end
    end
  end

  // Issues one request; returns on the falling edge right after the accepting clock edge.
  task automatic do_req(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    e.rdata   = exp_rd;
    e.err     = exp_err;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cache_hold !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || updated !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: hold=%0b ready=%0b rsp_valid=%0b updated=%0b, expected 0 1 0 0",
               cache_hold, req_ready, rsp_valid, updated);
    end
    checks++;
    if (thr !== 4'd3 || rst_on_write !== 1'b1 || rtab_limit !== 4'd8 || mshr_mask !== 2'b11) begin
      failures++;
      $display("FAIL reset_active: thr=%0d row=%0b limit=%0d mask=%b, expected 3 1 8 11",
               thr, rst_on_write, rtab_limit, mshr_mask);
    end
    rst_n = 1'b1;
    do_req(1'b0, 2'd0, 32'h0, 32'h1, 1'b0);
    do_req(1'b0, 2'd1, 32'h0, 32'h3, 1'b0);
    do_req(1'b0, 2'd2, 32'h0, 32'h8, 1'b0);
    do_req(1'b0, 2'd3, 32'h0, 32'h3, 1'b0);
  endtask

  task automatic test_write_read();
    do_req(1'b1, 2'd1, 32'h9, 32'h0, 1'b0);
    do_req(1'b0, 2'd1, 32'h0, 32'h9, 1'b0);
    checks++;
    if (thr !== 4'd3) begin
      failures++;
      $display("FAIL thr_before_apply: got %0d, expected 3", thr);
    end
  endtask

  task automatic test_illegal();
    do_req(1'b1, 2'd2, 32'h0, 32'h0, 1'b1);
    do_req(1'b1, 2'd2, 32'h9, 32'h0, 1'b1);
    do_req(1'b1, 2'd3, 32'h0, 32'h0, 1'b1);
    do_req(1'b0, 2'd2, 32'h0, 32'h8, 1'b0);
    do_req(1'b0, 2'd3, 32'h0, 32'h3, 1'b0);
    do_req(1'b1, 2'd2, 32'h1, 32'h0, 1'b0);
    do_req(1'b0, 2'd2, 32'h0, 32'h1, 1'b0);
  endtask

  task automatic test_apply_latency();
    cache_idle = 1'b1;
    do_req(1'b1, 2'd0, 32'h3, 32'h0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      logic       e_hold;
      logic       e_upd;
      logic [3:0] e_thr;
      logic [3:0] e_lim;
      e_hold = (k <= 5);
      e_upd  = (k == 6);
      e_thr  = (k >= 6) ? 4'd9 : 4'd3;
      e_lim  = (k >= 6) ? 4'd1 : 4'd8;
      checks++;
      if (cache_hold !== e_hold || updated !== e_upd || thr !== e_thr || rtab_limit !== e_lim) begin
        failures++;
        $display("FAIL apply_latency T+%0d: hold=%0b upd=%0b thr=%0d limit=%0d, expected %0b %0b %0d %0d",
                 k, cache_hold, updated, thr, rtab_limit, e_hold, e_upd, e_thr, e_lim);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_idle_toggle();
    logic [7:0] pat;
    pat = 8'b1111_0111;
    do_req(1'b1, 2'd3, 32'h1, 32'h0, 1'b0);
    cache_idle = 1'b1;
    do_req(1'b1, 2'd0, 32'h3, 32'h0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      logic       e_hold;
      logic       e_upd;
      logic [1:0] e_mask;
      cache_idle = (k <= 8) ? pat[k-1] : 1'b1;
      e_hold = (k <= 9);
      e_upd  = (k == 10);
      e_mask = (k >= 10) ? 2'b01 : 2'b11;
      checks++;
      if (cache_hold !== e_hold || updated !== e_upd || mshr_mask !== e_mask || thr !== 4'd9) begin
        failures++;
        $display("FAIL idle_toggle T+%0d: hold=%0b upd=%0b mask=%b thr=%0d, expected %0b %0b %b 9",
                 k, cache_hold, updated, mshr_mask, thr, e_hold, e_upd, e_mask);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    int hold_cycles;
    int upd_seen;
    hold_cycles = 0;
    upd_seen    = 0;
    do_req(1'b1, 2'd1, 32'h5, 32'h0, 1'b0);
    cache_idle = 1'b0;
    do_req(1'b1, 2'd0, 32'h3, 32'h0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (updated) upd_seen++;
      if (!cache_hold) break;
      hold_cycles++;
      @(negedge clk);
    end
    checks++;
    if (hold_cycles !== 64 || upd_seen !== 0) begin
      failures++;
      $display("FAIL timeout_hold: hold cycles=%0d updated pulses=%0d, expected 64 and 0", hold_cycles, upd_seen);
    end
    checks++;
    if (thr !== 4'd9 || rtab_limit !== 4'd1 || mshr_mask !== 2'b01 || rst_on_write !== 1'b1) begin
      failures++;
      $display("FAIL timeout_active: thr=%0d limit=%0d mask=%b row=%0b, expected 9 1 01 1",
               thr, rtab_limit, mshr_mask, rst_on_write);
    end
    cache_idle = 1'b1;
    do_req(1'b0, 2'd0, 32'h0, 32'h9, 1'b0);
    do_req(1'b1, 2'd0, 32'h9, 32'h0, 1'b0);
    do_req(1'b0, 2'd0, 32'h0, 32'h1, 1'b0);
    do_req(1'b0, 2'd1, 32'h0, 32'h5, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    int upd_seen;
    int hold_seen;
    upd_seen  = 0;
    hold_seen = 0;
    do_req(1'b1, 2'd1, 32'h7, 32'h0, 1'b0);
    cache_idle = 1'b0;
    do_req(1'b1, 2'd0, 32'h3, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (cache_hold !== 1'b1) begin
      failures++;
      $display("FAIL drain_before_reset: hold=%0b, expected 1", cache_hold);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (cache_hold !== 1'b0 || req_ready !== 1'b1 || updated !== 1'b0 || thr !== 4'd3 ||
        rtab_limit !== 4'd8 || mshr_mask !== 2'b11 || rst_on_write !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_drain: hold=%0b ready=%0b upd=%0b thr=%0d limit=%0d mask=%b row=%0b, expected 0 1 0 3 8 11 1",
               cache_hold, req_ready, updated, thr, rtab_limit, mshr_mask, rst_on_write);
    end
    rst_n      = 1'b1;
    cache_idle = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (updated) upd_seen++;
      if (cache_hold) hold_seen++;
    end
    checks++;
    if (upd_seen !== 0 || hold_seen !== 0) begin
      failures++;
      $display("FAIL after_reset_quiet: updated pulses=%0d hold cycles=%0d, expected 0 0", upd_seen, hold_seen);
    end
    do_req(1'b0, 2'd0, 32'h0, 32'h1, 1'b0);
    do_req(1'b0, 2'd1, 32'h0, 32'h3, 1'b0);
    do_req(1'b0, 2'd2, 32'h0, 32'h8, 1'b0);
    do_req(1'b0, 2'd3, 32'h0, 32'h3, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 2'd0;
    req_wdata  = 32'h0;
    cache_idle = 1'b1;
    test_reset();
    test_write_read();
    test_illegal();
    test_apply_latency();
    test_idle_toggle();
    test_timeout();
    test_reset_mid_drain();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL missing_rsp: %0d responses outstanding, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
